// File: rtl/display_driver_rgb_pipe.sv
// Bit-plane extraction and delay pipeline for the LED panel RGB data pins.
// Selects one bit-plane of every colour channel and delays it pipe_length enabled edges.
module display_driver_rgb_pipe #(
    parameter int pipe_length = 2,
    parameter int segments    = 1,
    parameter int bitwidth    = 8,
    localparam int sel_w      = (bitwidth > 1) ? $clog2(bitwidth) : 1,
    localparam int chans      = 3 * segments
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic [sel_w-1:0]             select,
    input  logic [chans*bitwidth-1:0]    pixel,
    output logic [chans-1:0]             rgb
);

    logic [chans-1:0] in_bits;
    logic [chans-1:0] stage [pipe_length];

    always_comb begin
        in_bits = '0;
        for (int k = 0; k < chans; k++) begin
            logic [bitwidth-1:0] ch;
            ch = pixel[k*bitwidth +: bitwidth];
            in_bits[k] = ch[select];
        end
    end

    // select is used only here, so it is effectively sampled together with pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < pipe_length; i++) begin
                stage[i] <= '0;
            end
        end else if (go) begin
            stage[0] <= in_bits;
            for (int i = 1; i < pipe_length; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign rgb = stage[pipe_length-1];

endmodule

// File: tb/tb_display_driver_rgb_pipe.sv
// Directed bench for display_driver_rgb_pipe with default parameters (2 stages, 1 segment, 8 bits).
module tb_display_driver_rgb_pipe;

    logic        clk;
    logic        rst;
    logic        go;
    logic [2:0]  select;
    logic [23:0] pixel;
    logic [2:0]  rgb;

    int n_total = 0;
    int n_bad   = 0;
    logic [2:0] e0, e1;

    display_driver_rgb_pipe dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .select (select),
        .pixel  (pixel),
        .rgb    (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected-value shadow of the two stages, used by the sweeps
    task automatic step_exp(input string tag, input logic [2:0] nxt);
        step();
        e1 = e0;
        e0 = nxt;
        check(tag, rgb, e1);
    endtask

    initial begin
        rst    = 1'b0;
        go     = 1'b0;
        select = 3'd0;
        pixel  = 24'h0;
        #1;
        check("reset", rgb, 3'b000);
        #11;
        rst = 1'b1;
        #1;
        check("reset_release", rgb, 3'b000);

        // fill from reset
        pixel = 24'h0000FF;
        go    = 1'b1;
        step(); check("fill_e1", rgb, 3'b000);
        step(); check("fill_e2", rgb, 3'b001);

        // one-cycle inline change
        pixel = 24'h0000F0;
        step(); check("inline_0", rgb, 3'b001);
        pixel = 24'h0000FF;
        step(); check("inline_1", rgb, 3'b000);
        step(); check("inline_2", rgb, 3'b001);

        // stall: input change while go is low must not be captured
        pixel = 24'h0000F0;
        go    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_hold", rgb, 3'b001);
        end
        go = 1'b1;
        step(); check("stall_resume0", rgb, 3'b001);
        step(); check("stall_resume1", rgb, 3'b000);

        // bit-plane sweep, low byte alternating 00/FF; stage 0 currently holds 0
        e0 = 3'b000;
        for (int s = 0; s < 8; s++) begin
            select = 3'(s);
            pixel  = (s % 2) ? 24'h0000FF : 24'h000000;
            step_exp("sweep_ff", (s % 2) ? 3'b001 : 3'b000);
        end
        // one-hot sweep: only the selected bit set, then only it cleared
        for (int s = 0; s < 8; s++) begin
            logic [23:0] oh;
            oh     = 24'h1 << s;
            select = 3'(s);
            pixel  = oh;
            step_exp("sweep_onehot", 3'b001);
            pixel  = oh ^ 24'h0000FF;
            step_exp("sweep_onecold", 3'b000);
        end
        step_exp("sweep_flush", 3'b000);

        // channel mapping
        pixel  = 24'h800100;
        select = 3'd0;
        step(); step(); check("chan_sel0", rgb, 3'b010);
        select = 3'd7;
        step(); check("chan_sel7_d1", rgb, 3'b010);
        step(); check("chan_sel7", rgb, 3'b100);

        // async reset between edges
        #3;
        rst = 1'b0;
        #1;
        check("async_rst", rgb, 3'b000);
        #2;
        rst = 1'b1;
        step(); check("post_rst_e1", rgb, 3'b000);
        step(); check("post_rst_e2", rgb, 3'b100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/display_driver_rgb_pipe.md
# display_driver_rgb_pipe

Bit-plane extraction and delay pipeline for the LED display driver. Each cycle the block selects one bit (the current bit-plane) from every colour channel of every segment's pixel and pushes the 3-bit RGB group per segment into a fixed-length shift pipeline. The delay matches the latency of the panel address/latch sequencing. The pipeline advances only when `go` is high and holds its contents otherwise. The block sits between the frame-buffer read path and the panel's serial RGB data pins.

## Interface
- `pipe_length`, default 2: number of register stages between input sampling and `rgb`; must be ≥ 1.
- `segments`, default 1: number of independent panel segments (RGB triplets) handled in parallel.
- `bitwidth`, default 8: bits per colour channel; also the number of bit-planes.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, asynchronous, active-low; clears every pipeline stage.
- `go`  input  1: advance enable; when 1 the pipeline shifts on the rising edge, when 0 all stages hold.
- `select`  input  $clog2(bitwidth): bit-plane index, 0 = LSB of each channel.
- `pixel`  input  3·segments·bitwidth: packed channels; channel k (k = 3·s + c, c ∈ {0,1,2}) occupies bits [k·bitwidth +: bitwidth].
- `rgb`  output  3·segments: `rgb[3·s + c]` is the delayed selected bit of channel c of segment s.

## Operation
- Input mapping (combinational, before stage 0): `in[k] = pixel[k·bitwidth + select]` for k = 0 .. 3·segments−1.
  - With defaults, `in[0] = pixel[select]`, `in[1] = pixel[8+select]`, `in[2] = pixel[16+select]`.
- `select` and `pixel` are sampled together, at the same edge, into stage 0. `select` is not pipelined separately.
- Pipeline: stages 0 .. pipe_length−1, each 3·segments bits wide.
  - On a rising edge with `go` = 1: stage0 ← in; stage i ← stage i−1.
  - With `go` = 0: no stage changes, and input changes are ignored.
- `rgb` is driven directly by the final stage (registered output, no combinational path from inputs).
- `select` values ≥ bitwidth are not supported (result undefined; `bitwidth` is normally a power of two).
- No state machine; the block is a gated shift register plus a bit multiplexer.

## Timing
- Reset: asserting `rst` low immediately (asynchronously) clears all stages. `rgb` = 0 while reset is held and until new data reaches the last stage.
- Latency: data sampled at rising edge N appears on `rgb` after edge N + pipe_length − 1 (pipe_length edges with `go` = 1, counting the sampling edge).
  - With pipe_length = 2, a value presented before edge 1 is visible after edge 2.
- Latency is counted in enabled edges only. Edges with `go` = 0 insert holds but never drop or duplicate data.
- Back-to-back changes of `pixel` or `select` on consecutive enabled edges emerge on consecutive cycles, in order.
- Reset mid-stream discards all in-flight data. After release, the first pipe_length−1 enabled edges still output 0.
- `go` deasserted on the same edge as an input change: the change is not captured.

## Test plan
- Fill from reset (defaults), with `pixel` = 0x0000FF, `select` = 0, `go` = 1:
  - `rgb` = 000 after edge 1.
  - `rgb` = 001 after edge 2.
- Inline change from the state above: drive `pixel` = 0x0000F0 for one cycle, then 0x0000FF.
  - `rgb` sequence is 001, 000, 001 (two-cycle delayed).
- Stall, starting from `rgb` = 001 with stage 0 = 1:
  - Set `pixel` = 0x0000F0 and `go` = 0 for 3 edges -> `rgb` stays 001.
  - Re-enable `go` -> `rgb` reads 001, then 000.
- Bit-plane sweep: for `select` = 0..7, alternate the low byte of `pixel` between 0x00 and 0xFF, others 0.
  - Each value read two edges later gives `rgb` = 000 or 001, respectively.
- Channel mapping: `pixel` = 0x800100, `select` = 0 -> `rgb` = 010. With `select` = 7 -> `rgb` = 100.
- Async reset: assert `rst` low mid-stream between edges.
  - `rgb` goes to 000 immediately.
  - After release, the first enabled edge still yields 000.
